// File: rtl/uart_tx_pin_drv.sv
// UART transmit serializer: byte FIFO feeding a start/8-data/parity/stop framer.
// o_tx is a flop output so the pad buffer downstream never sees a glitch.
module uart_tx_pin_drv #(
    parameter int log2_fifo = 4,
    parameter int scaler_w  = 16
) (
    input  logic                i_clk,
    input  logic                i_nrst,
    input  logic [scaler_w-1:0] i_scaler,
    input  logic                i_parity_en,
    input  logic                i_stop2,
    input  logic                i_we,
    input  logic [7:0]          i_wdata,
    output logic                o_full,
    output logic                o_empty,
    output logic                o_busy,
    output logic                o_overflow,
    output logic                o_tx
);

    localparam int Depth = 2 ** log2_fifo;
    localparam logic [log2_fifo-1:0] PtrOne  = log2_fifo'(1);
    localparam logic [log2_fifo:0]   CntOne  = (log2_fifo + 1)'(1);
    localparam logic [log2_fifo:0]   CntFull = (log2_fifo + 1)'(Depth);
    localparam logic [scaler_w-1:0]  ScOne   = scaler_w'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            mem_q [Depth];
    logic [log2_fifo-1:0]  wr_ptr_q, wr_ptr_d;
    logic [log2_fifo-1:0]  rd_ptr_q, rd_ptr_d;
    logic [log2_fifo:0]    count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q, busy_d;
    logic                  tx_q, tx_d;
    logic [scaler_w-1:0]   scaler_q, scaler_d;
    logic [scaler_w-1:0]   cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  stop2_q, stop2_d;
    logic                  parity_q, parity_d;
    logic [7:0]            shift_q, shift_d;
    logic [2:0]            idx_q, idx_d;
    logic                  wr_en;
    logic                  pop;
    logic                  tick;

    assign wr_en = i_we & ~full_q;
    assign pop   = (state_q == IDLE) & ~empty_q;
    // scaler_q is never 0: a requested 0 is latched as 1
    assign tick  = (cnt_q == (scaler_q - ScOne));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CntFull);
        empty_d = (count_d == '0);
        ovf_d   = i_we & full_q;
    end

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        scaler_d = scaler_q;
        par_en_d = par_en_q;
        stop2_d  = stop2_q;
        parity_d = parity_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        if (state_q == IDLE || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ScOne;
        end
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d  = START;
                    shift_d  = mem_q[rd_ptr_q];
                    parity_d = ^mem_q[rd_ptr_q];
                    scaler_d = (i_scaler == '0) ? ScOne : i_scaler;
                    par_en_d = i_parity_en;
                    stop2_d  = i_stop2;
                    tx_d     = 1'b0;
                    cnt_d    = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q != 3'd7) begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[1];
                    end else if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = parity_q;
                    end else begin
                        state_d = STOP1;
                        tx_d    = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP1;
                    tx_d    = 1'b1;
                end
            end
            STOP1: begin
                if (tick) begin
                    state_d = stop2_q ? STOP2 : IDLE;
                end
            end
            STOP2: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            tx_q     <= 1'b1;
            scaler_q <= ScOne;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            parity_q <= 1'b0;
            shift_q  <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            tx_q     <= tx_d;
            scaler_q <= scaler_d;
            cnt_q    <= cnt_d;
            par_en_q <= par_en_d;
            stop2_q  <= stop2_d;
            parity_q <= parity_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
        end
    end

    // Storage needs no reset; a cleared count makes old entries unreachable
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_busy     = busy_q;
    assign o_overflow = ovf_q;
    assign o_tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_pin_drv.sv
// Self-checking bench for uart_tx_pin_drv: directed and randomized byte sequences
// compared cycle by cycle against an expected line waveform built from frame rules.
module tb_uart_tx_pin_drv;

    localparam int LOG2  = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        i_nrst = 1'b0;
    logic [15:0] i_scaler = '0;
    logic        i_parity_en = 1'b0;
    logic        i_stop2 = 1'b0;
    logic        i_we = 1'b0;
    logic [7:0]  i_wdata = '0;
    logic        o_full, o_empty, o_busy, o_overflow, o_tx;

    int n_assert = 0;
    int n_fail   = 0;

    bit         exp_tx[$];
    bit         exp_busy[$];
    logic [7:0] wr_q[$];

    uart_tx_pin_drv #(.log2_fifo(LOG2), .scaler_w(16)) dut (
        .i_clk      (clk),
        .i_nrst     (i_nrst),
        .i_scaler   (i_scaler),
        .i_parity_en(i_parity_en),
        .i_stop2    (i_stop2),
        .i_we       (i_we),
        .i_wdata    (i_wdata),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_busy     (o_busy),
        .o_overflow (o_overflow),
        .o_tx       (o_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push(input bit t, input bit b);
        exp_tx.push_back(t);
        exp_busy.push_back(b);
    endtask

    // One frame on the line: start, data LSB first, optional even parity, stop bit(s)
    task automatic add_frame(input logic [7:0] d, input int s, input bit p, input bit st);
        int per;
        bit bits[$];
        per = (s == 0) ? 1 : s;
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(d[k]);
        if (p) bits.push_back(^d);
        bits.push_back(1'b1);
        if (st) bits.push_back(1'b1);
        foreach (bits[k]) repeat (per) push(bits[k], 1'b1);
    endtask

    // Writes wr_q on consecutive cycles (called at a negedge with the DUT idle and
    // empty). Frame configuration switches to set 2 from loop index chg onwards.
    task automatic run_seq(input int s1, input bit p1, input bit t1, input int chg,
                           input int s2, input bit p2, input bit t2, input string tag);
        bit         acc_f[$];
        logic [7:0] acc[$];
        int         starts[$];
        int         cnt, t, sp, nwr;
        bit         use2;
        nwr = wr_q.size();
        exp_tx.delete();
        exp_busy.delete();
        cnt = 0;
        for (int j = 0; j < nwr; j++) begin
            acc_f.push_back(cnt != DEPTH);
            if (cnt != DEPTH) begin
                acc.push_back(wr_q[j]);
                cnt++;
            end
            if (j == 1) cnt--;
        end
        push(1'b1, 1'b0);
        foreach (acc[k]) begin
            t = exp_tx.size();
            starts.push_back(t);
            use2 = (chg >= 0) && (t > chg);
            add_frame(acc[k], use2 ? s2 : s1, use2 ? p2 : p1, use2 ? t2 : t1);
            push(1'b1, 1'b0);
        end
        repeat (3) push(1'b1, 1'b0);

        i_scaler    = 16'(s1);
        i_parity_en = p1;
        i_stop2     = t1;
        i_we        = 1'b1;
        i_wdata     = wr_q[0];
        cnt = 0;
        sp  = 0;
        for (int i = 0; i < exp_tx.size(); i++) begin
            @(negedge clk);
            if (i + 1 < nwr) i_wdata = wr_q[i+1];
            else i_we = 1'b0;
            if (i == chg) begin
                i_scaler    = 16'(s2);
                i_parity_en = p2;
                i_stop2     = t2;
            end
            if (i < nwr && acc_f[i]) cnt++;
            if (sp < starts.size() && starts[sp] == i) begin
                cnt--;
                sp++;
            end
            chk({tag, "_tx"},    o_tx,       exp_tx[i]);
            chk({tag, "_busy"},  o_busy,     exp_busy[i]);
            chk({tag, "_empty"}, o_empty,    cnt == 0);
            chk({tag, "_full"},  o_full,     cnt == DEPTH);
            chk({tag, "_ovf"},   o_overflow, (i < nwr) && !acc_f[i]);
        end
    endtask

    initial begin
        int nb, s1, s2, chg;
        bit p1, p2, t1, t2;

        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", o_tx, 1'b1);
            chk("rst_empty", o_empty, 1'b1);
            chk("rst_full", o_full, 1'b0);
            chk("rst_busy", o_busy, 1'b0);
            chk("rst_ovf", o_overflow, 1'b0);
        end
        i_nrst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("idle_tx", o_tx, 1'b1);
            chk("idle_empty", o_empty, 1'b1);
            chk("idle_full", o_full, 1'b0);
            chk("idle_busy", o_busy, 1'b0);
        end

        wr_q = '{8'hA5};
        run_seq(4, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, "8n1");

        wr_q = '{8'h07};
        run_seq(2, 1'b1, 1'b1, -1, 0, 1'b0, 1'b0, "par2s");

        wr_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_seq(100, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, "ovf");

        // Second frame starts at index 12; index 15 is inside its data bits
        wr_q = '{8'hFF, 8'h3C, 8'hC3};
        run_seq(0, 1'b0, 1'b0, 15, 3, 1'b0, 1'b0, "scl");

        for (int r = 0; r < 8; r++) begin
            nb = $urandom_range(1, 6);
            wr_q.delete();
            for (int k = 0; k < nb; k++) wr_q.push_back(8'($urandom));
            s1  = $urandom_range(0, 5);
            s2  = $urandom_range(0, 5);
            p1  = 1'($urandom);
            p2  = 1'($urandom);
            t1  = 1'($urandom);
            t2  = 1'($urandom);
            chg = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 80)) : -1;
            run_seq(s1, p1, t1, chg, s2, p2, t2, "rnd");
        end

        i_scaler    = 16'd4;
        i_parity_en = 1'b0;
        i_stop2     = 1'b0;
        i_we        = 1'b1;
        i_wdata     = 8'h5A;
        @(negedge clk);
        i_wdata = 8'h11;
        @(negedge clk);
        i_wdata = 8'h22;
        @(negedge clk);
        i_we = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_busy_pre", o_busy, 1'b1);
        chk("midrst_empty_pre", o_empty, 1'b0);
        #2 i_nrst = 1'b0;
        #1;
        chk("midrst_tx", o_tx, 1'b1);
        chk("midrst_empty", o_empty, 1'b1);
        chk("midrst_busy", o_busy, 1'b0);
        chk("midrst_full", o_full, 1'b0);
        @(negedge clk);
        @(negedge clk);
        i_nrst = 1'b1;
        repeat (60) begin
            @(negedge clk);
            chk("postrst_tx", o_tx, 1'b1);
            chk("postrst_busy", o_busy, 1'b0);
            chk("postrst_empty", o_empty, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
